matrix_alu_unit: RTL and testbench

//  Downstream consumer of the 256-bit matrix memory. Latches two 4x4 matrices of 16-bit elements
//  (Src1, Src2) from inputDataBus, which carries memory's outputDataBus. Computes ADD, SUB, MUL,

---
 rtl/matrix_alu_unit.sv | 185 ++++++++++++++++++
 tb/tb_matrix_alu_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_alu_unit.sv
// 4x4 matrix ALU (16-bit elements): latches two operands from the memory bus, computes one result
// element per cycle, returns it on a shared tri-state bus. Define ALU_SATURATE_EN for unsigned saturation.

module matrix_alu_mul_lane #(
  parameter int W = 16
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
endmodule

module matrix_alu_unit #(
  parameter logic [3:0] ALU_ID = 4'h2,
  parameter int         ELEM_W = 16,
  parameter int         DIM    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [15:0]                addressBus,
  input  logic [DIM*DIM*ELEM_W-1:0]  inputDataBus,
  input  logic                       loadSrc1,
  input  logic                       loadSrc2,
  input  logic [2:0]                 opcode,
  input  logic [ELEM_W-1:0]          immediate,
  input  logic                       start,
  input  logic                       readFromALU,
  inout  wire  [DIM*DIM*ELEM_W-1:0]  outputDataBus,
  output logic                       busy,
  output logic                       done,
  output logic                       illegalOp
);
  localparam int NUM_EL = DIM * DIM;
  localparam int IW     = $clog2(NUM_EL);
  localparam int DW     = $clog2(DIM);
  localparam int PW     = 2 * ELEM_W;
  localparam int ACC_W  = PW + DW;
  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_MUL   = 3'd2;
  localparam logic [2:0] OP_TRANS = 3'd3;
  localparam logic [2:0] OP_SCALE = 3'd4;

`ifdef ALU_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef logic [NUM_EL-1:0][ELEM_W-1:0] mat_t;
  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [2:0]        op_q, op_d;
  logic [ELEM_W-1:0] imm_q, imm_d;
  mat_t              src1_q, src1_d, src2_q, src2_d, result_q, result_d;
  logic              busy_q, busy_d, done_q, done_d, illegal_q, illegal_d;
  logic              drive_q, drive_d;

  logic sel;
  logic unused_addr;
  assign sel         = (addressBus[15:12] == ALU_ID);
  assign unused_addr = ^addressBus[11:0];

  // Element coordinates of the element being produced this cycle.
  logic [DW-1:0] row, col;
  assign row = idx_q[IW-1:DW];
  assign col = idx_q[DW-1:0];

  logic [ELEM_W-1:0] a_rc, b_rc, a_cr;
  assign a_rc = src1_q[idx_q];
  assign b_rc = src2_q[idx_q];
  assign a_cr = src1_q[{col, row}];

  logic [DIM-1:0][PW-1:0] prod;
  for (genvar k = 0; k < DIM; k++) begin : g_lane
    matrix_alu_mul_lane #(.W(ELEM_W)) u_lane (
      .a (src1_q[{row, DW'(k)}]),
      .b (src2_q[{DW'(k), col}]),
      .p (prod[k])
    );
  end

  logic [ACC_W-1:0]  acc;
  logic [ELEM_W:0]   add_w;
  logic [PW-1:0]     scale_w;
  logic [ELEM_W-1:0] elem;

  always_comb begin
    acc = '0;
    for (int k = 0; k < DIM; k++) acc = acc + ACC_W'(prod[k]);
    add_w   = {1'b0, a_rc} + {1'b0, b_rc};
    scale_w = {{ELEM_W{1'b0}}, a_rc} * {{ELEM_W{1'b0}}, imm_q};
    elem    = '0;
    case (op_q)
      OP_ADD:   elem = (SAT_EN && add_w[ELEM_W]) ? '1 : add_w[ELEM_W-1:0];
      OP_SUB:   elem = (SAT_EN && (a_rc < b_rc)) ? '0 : a_rc - b_rc;
      OP_MUL:   elem = (SAT_EN && |acc[ACC_W-1:ELEM_W]) ? '1 : acc[ELEM_W-1:0];
      OP_TRANS: elem = a_cr;
      OP_SCALE: elem = (SAT_EN && |scale_w[PW-1:ELEM_W]) ? '1 : scale_w[ELEM_W-1:0];
      default:  elem = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    op_d      = op_q;
    imm_d     = imm_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    result_d  = result_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    illegal_d = illegal_q;
    drive_d   = sel && readFromALU;
    case (state_q)
      S_IDLE: begin
        if (sel && loadSrc1) src1_d = inputDataBus;
        if (sel && loadSrc2) src2_d = inputDataBus;
        if (sel && start) begin
          op_d      = opcode;
          imm_d     = immediate;
          idx_d     = '0;
          illegal_d = 1'b0;
          if (opcode > OP_SCALE) begin
            result_d  = '0;
            illegal_d = 1'b1;
            done_d    = 1'b1;
            state_d   = S_DONE;
          end else begin
            busy_d  = 1'b1;
            state_d = S_COMPUTE;
          end
        end
      end
      S_COMPUTE: begin
        result_d[idx_q] = elem;
        idx_d           = idx_q + 1'b1;
        if (idx_q == IW'(NUM_EL - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      op_q      <= '0;
      imm_q     <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      drive_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      op_q      <= op_d;
      imm_q     <= imm_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      drive_q   <= drive_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign illegalOp     = illegal_q;
  assign outputDataBus = drive_q ? result_q : {(NUM_EL*ELEM_W){1'bz}};
endmodule

// File: tb/tb_matrix_alu_unit.sv
// Directed-vector bench for matrix_alu_unit: table of operations with hand-computed results,
// plus sequences for select gating, busy-time protocol and reset abort mid-MUL.

module tb_matrix_alu_unit;
  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [15:0]  imm;
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] exp;
    bit           ill;
  } vec_t;

`ifdef ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [255:0] RAMP  = 256'h000f_000e_000d_000c_000b_000a_0009_0008_0007_0006_0005_0004_0003_0002_0001_0000;
  localparam logic [255:0] IDENT = 256'h0001_0000_0000_0000_0000_0001_0000_0000_0000_0000_0001_0000_0000_0000_0000_0001;
  localparam logic [255:0] TRAMP = 256'h000f_000b_0007_0003_000e_000a_0006_0002_000d_0009_0005_0001_000c_0008_0004_0000;
  localparam logic [255:0] RAMP3 = 256'h002d_002a_0027_0024_0021_001e_001b_0018_0015_0012_000f_000c_0009_0006_0003_0000;
  localparam logic [255:0] MROWS = {{4{16'h0036}}, {4{16'h0026}}, {4{16'h0016}}, {4{16'h0006}}};

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  addressBus;
  logic [255:0] inputDataBus;
  logic         loadSrc1, loadSrc2;
  logic [2:0]   opcode;
  logic [15:0]  immediate;
  logic         start, readFromALU;
  wire  [255:0] outputDataBus;
  logic         busy, done, illegalOp;

  matrix_alu_unit dut (
    .clk(clk), .reset(reset), .addressBus(addressBus), .inputDataBus(inputDataBus),
    .loadSrc1(loadSrc1), .loadSrc2(loadSrc2), .opcode(opcode), .immediate(immediate),
    .start(start), .readFromALU(readFromALU), .outputDataBus(outputDataBus),
    .busy(busy), .done(done), .illegalOp(illegalOp)
  );

  always #5 clk = ~clk;

  int           n_vec = 0;
  int           n_bad = 0;
  vec_t         vt[12];
  vec_t         v;
  logic [255:0] partial;

  function automatic logic [255:0] fill(input logic [15:0] x);
    return {16{x}};
  endfunction

  function automatic vec_t mk(input string name, input logic [2:0] op, input logic [15:0] imm,
                              input logic [255:0] a, input logic [255:0] b,
                              input logic [255:0] exp, input bit ill);
    vec_t r;
    r.name = name; r.op = op; r.imm = imm; r.a = a; r.b = b; r.exp = exp; r.ill = ill;
    return r;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_ne(input string name, input logic [255:0] act, input logic [255:0] not_exp);
    n_vec++;
    if (act === not_exp) begin
      n_bad++;
      $display("FAIL %s: bus still shows %h, expected it released", name, act);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Loads Src1, then Src2 on the same edge as start; disturb>0 injects load/start while busy.
  task automatic run_vec(input vec_t tv, input bit do_load, input int disturb);
    int bc  = 0;
    int dat = 0;
    @(negedge clk);
    addressBus = 16'h2000;
    if (do_load) begin
      inputDataBus = tv.a; loadSrc1 = 1'b1;
      @(negedge clk);
      loadSrc1 = 1'b0; inputDataBus = tv.b; loadSrc2 = 1'b1;
    end
    opcode = tv.op; immediate = tv.imm; start = 1'b1;
    @(negedge clk);
    loadSrc2 = 1'b0; start = 1'b0;
    for (int cyc = 1; cyc <= 40 && dat == 0; cyc++) begin
      if (busy) bc++;
      if (done) dat = cyc;
      else begin
        if (cyc == disturb) begin
          inputDataBus = fill(16'h0100); loadSrc1 = 1'b1; loadSrc2 = 1'b1;
          opcode = 3'd1; start = 1'b1;
        end else begin
          loadSrc1 = 1'b0; loadSrc2 = 1'b0; start = 1'b0;
        end
        @(negedge clk);
      end
    end
    check_int({tv.name, " busy cycles"}, bc, tv.ill ? 0 : 16);
    check_int({tv.name, " done cycle"}, dat, tv.ill ? 1 : 17);
    @(negedge clk);
    check_int({tv.name, " done pulse"}, int'(done), 0);
    readFromALU = 1'b1;
    @(negedge clk);
    check({tv.name, " result"}, outputDataBus, tv.exp);
    readFromALU = 1'b0;
    check_int({tv.name, " illegalOp"}, int'(illegalOp), int'(tv.ill));
  endtask

  initial begin
    reset = 1'b1; addressBus = '0; inputDataBus = '0; loadSrc1 = 1'b0; loadSrc2 = 1'b0;
    opcode = '0; immediate = '0; start = 1'b0; readFromALU = 1'b0;

    vt[0]  = mk("add",        3'd0, 16'd0, fill(16'h0003), fill(16'h0013), fill(16'h0016), 1'b0);
    vt[1]  = mk("sub 3-5",    3'd1, 16'd0, fill(16'h0003), fill(16'h0005),
                SAT ? fill(16'h0000) : fill(16'hfffe), 1'b0);
    vt[2]  = mk("sub 13-3",   3'd1, 16'd0, fill(16'h0013), fill(16'h0003), fill(16'h0010), 1'b0);
    vt[3]  = mk("add wrap",   3'd0, 16'd0, fill(16'hffff), fill(16'h0002),
                SAT ? fill(16'hffff) : fill(16'h0001), 1'b0);
    vt[4]  = mk("mul ident",  3'd2, 16'd0, fill(16'h0001), IDENT, fill(16'h0001), 1'b0);
    vt[5]  = mk("mul ramp",   3'd2, 16'd0, RAMP, fill(16'h0001), MROWS, 1'b0);
    vt[6]  = mk("mul wrap",   3'd2, 16'd0, fill(16'h0100), fill(16'h0100),
                SAT ? fill(16'hffff) : fill(16'h0000), 1'b0);
    vt[7]  = mk("transpose",  3'd3, 16'd0, RAMP, fill(16'h0000), TRAMP, 1'b0);
    vt[8]  = mk("scale wrap", 3'd4, 16'd2, fill(16'h8000), fill(16'h0000),
                SAT ? fill(16'hffff) : fill(16'h0000), 1'b0);
    vt[9]  = mk("scale ramp", 3'd4, 16'd3, RAMP, fill(16'h0000), RAMP3, 1'b0);
    vt[10] = mk("illegal 6",  3'd6, 16'd0, RAMP, RAMP, '0, 1'b1);
    vt[11] = mk("add after",  3'd0, 16'd0, fill(16'h0003), fill(16'h0013), fill(16'h0016), 1'b0);

    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_int("reset busy", int'(busy), 0);
    check_int("reset done", int'(done), 0);
    check_int("reset illegalOp", int'(illegalOp), 0);
    reset = 1'b1;
    @(negedge clk);
    addressBus = 16'h2000; readFromALU = 1'b1;
    @(negedge clk);
    check("reset result", outputDataBus, '0);
    readFromALU = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_vec(vt[i], 1'b1, 0);
      if (vt[i].ill) begin
        repeat (3) @(negedge clk);
        check_int("illegalOp held", int'(illegalOp), 1);
      end
    end

    // Bus drive follows the select of the previous edge.
    @(negedge clk);
    addressBus = 16'h1000; readFromALU = 1'b1;
    @(negedge clk);
    check_ne("read unselected", outputDataBus, fill(16'h0016));
    addressBus = 16'h2000;
    @(negedge clk);
    check("read selected", outputDataBus, fill(16'h0016));
    readFromALU = 1'b0;

    // Unselected load/start must not disturb state.
    addressBus = 16'h1000; inputDataBus = fill(16'h0100); loadSrc1 = 1'b1; opcode = 3'd1; start = 1'b1;
    @(negedge clk);
    check_int("unselected start", int'(busy), 0);
    loadSrc1 = 1'b0; start = 1'b0;
    run_vec(mk("reuse ops", 3'd0, 16'd0, '0, '0, fill(16'h0016), 1'b0), 1'b0, 0);

    v = vt[0]; v.name = "busy protocol";
    run_vec(v, 1'b1, 5);

    // Reset in the middle of a MUL, with the bus being read.
    @(negedge clk);
    addressBus = 16'h2000; inputDataBus = RAMP; loadSrc1 = 1'b1;
    @(negedge clk);
    loadSrc1 = 1'b0; inputDataBus = fill(16'h0001); loadSrc2 = 1'b1;
    @(negedge clk);
    loadSrc2 = 1'b0; opcode = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; readFromALU = 1'b1;
    repeat (7) @(negedge clk);
    check("partial mul", {144'd0, outputDataBus[111:0]},
          {144'd0, 16'h0016, 16'h0016, 16'h0016, {4{16'h0006}}});
    partial = outputDataBus;
    reset = 1'b0;
    #1;
    check_int("abort busy", int'(busy), 0);
    check_int("abort done", int'(done), 0);
    check_ne("abort bus", outputDataBus, partial);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort result cleared", outputDataBus, '0);
    readFromALU = 1'b0;
    v = vt[5]; v.name = "restart mul";
    run_vec(v, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_vec);
    $fatal(1, "watchdog");
  end
endmodule
